quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder_pkg.sv | 43 ++++
 rtl/quad_decoder_debounce_sync.sv | 51 +++++
 rtl/quad_decoder.sv | 101 ++++++++++
 tb/tb_quad_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Quadrature pair encodings, direction codes and the single-transition decode
// shared by the encoder front end.
package quad_decoder_pkg;

  typedef enum logic [1:0] {
    QP_00 = 2'b00,
    QP_01 = 2'b01,
    QP_11 = 2'b11,
    QP_10 = 2'b10
  } quad_pair_e;

  localparam logic signed [1:0] DIR_CW   = 2'sd1;
  localparam logic signed [1:0] DIR_NONE = 2'sd0;
  localparam logic signed [1:0] DIR_CCW  = -2'sd1;

  typedef struct packed {
    logic signed [1:0] dir;
    logic              illegal;
  } quad_step_t;

  function automatic quad_pair_e next_cw(quad_pair_e p);
    case (p)
      QP_00:   return QP_01;
      QP_01:   return QP_11;
      QP_11:   return QP_10;
      default: return QP_00;
    endcase
  endfunction

  // Both bits changing lands two places round the ring: neither neighbour.
  function automatic quad_step_t quad_decode(quad_pair_e prev, quad_pair_e cur);
    quad_step_t s;
    s.dir     = DIR_NONE;
    s.illegal = 1'b0;
    if (cur != prev) begin
      if (cur == next_cw(prev))      s.dir     = DIR_CW;
      else if (prev == next_cw(cur)) s.dir     = DIR_CCW;
      else                           s.illegal = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_decoder_debounce_sync.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one
// raw encoder channel.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic settled_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       prime1_q, prime2_q;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = 8'd0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      cnt_q    <= 8'd0;
      prime1_q <= 1'b0;
      prime2_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      prime1_q <= 1'b1;
      prime2_q <= prime1_q;
    end
  end

  assign level_o = level_q;
  // Only trust the compare once the synchroniser holds a post-reset sample.
  assign settled_o = prime2_q & (sync2_q == level_q);

endmodule

// File: rtl/quad_decoder.sv
// Rotary encoder front end: per-channel sync/debounce, quadrature decode,
// sub-step accumulation and a wrapping 2-bit position count.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STEP_DIV        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic signed [1:0] encoder_value,
  output logic              step_cw,
  output logic              step_ccw,
  output logic              glitch
);

  localparam logic signed [3:0] ACC_POS = 4'(STEP_DIV);
  localparam logic signed [3:0] ACC_NEG = -ACC_POS;

  logic              level_a, level_b, settled_a, settled_b;
  quad_pair_e        pair_cur, prev_q, prev_d;
  quad_step_t        dec;
  logic              armed_q, armed_d;
  logic signed [3:0] acc_q, acc_d, acc_sum;
  logic signed [1:0] value_q, value_d;
  logic              cw_q, cw_d, ccw_q, ccw_d, glitch_q, glitch_d;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (enc_a),
    .level_o   (level_a),
    .settled_o (settled_a)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (enc_b),
    .level_o   (level_b),
    .settled_o (settled_b)
  );

  assign pair_cur = quad_pair_e'({level_a, level_b});

  always_comb begin
    dec      = quad_decode(prev_q, pair_cur);
    prev_d   = pair_cur;
    armed_d  = armed_q | (settled_a & settled_b);
    acc_d    = acc_q;
    value_d  = value_q;
    cw_d     = 1'b0;
    ccw_d    = 1'b0;
    glitch_d = 1'b0;
    acc_sum  = acc_q + {{2{dec.dir[1]}}, dec.dir};
    // Until armed, pair changes only realign prev_q to the settled inputs.
    if (armed_q) begin
      if (dec.illegal) begin
        glitch_d = 1'b1;
      end else if (acc_sum == ACC_POS) begin
        acc_d   = 4'sd0;
        value_d = value_q + 2'sd1;
        cw_d    = 1'b1;
      end else if (acc_sum == ACC_NEG) begin
        acc_d   = 4'sd0;
        value_d = value_q - 2'sd1;
        ccw_d   = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= QP_00;
      armed_q  <= 1'b0;
      acc_q    <= 4'sd0;
      value_q  <= 2'sd0;
      cw_q     <= 1'b0;
      ccw_q    <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      armed_q  <= armed_d;
      acc_q    <= acc_d;
      value_q  <= value_d;
      cw_q     <= cw_d;
      ccw_q    <= ccw_d;
      glitch_q <= glitch_d;
    end
  end

  assign encoder_value = value_q;
  assign step_cw       = cw_q;
  assign step_ccw      = ccw_q;
  assign glitch        = glitch_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomised and directed checks of quad_decoder against a cycle-level
// behavioural model, for two parameter sets sharing the same stimulus.
module tb_quad_decoder;

  typedef struct packed {
    int         n;
    logic [1:0] raw1;
    logic [1:0] raw2;
    logic [1:0] deb;
    logic [1:0] prev;
    int         run_a;
    int         run_b;
    logic       armed;
    int         acc;
    int         val;
    logic       cw;
    logic       ccw;
    logic       gl;
  } mdl_t;

  logic clk, reset, enc_a, enc_b;
  logic signed [1:0] ev8, ev1;
  logic cw8, ccw8, gl8, cw1, ccw1, gl1;

  int   n_cmp, n_bad;
  bit   chk_en;
  mdl_t m8, m1;
  int   cnt_cw8, cnt_ccw8, cnt_gl8, cnt_cw1, cnt_ccw1, jump8;
  int   seq8[$];
  logic [1:0] last8, now8;
  logic [1:0] ring [4];
  int   exp_seq [5];

  quad_decoder #(.DEBOUNCE_CYCLES(8), .STEP_DIV(4)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .encoder_value(ev8), .step_cw(cw8), .step_ccw(ccw8), .glitch(gl8)
  );

  quad_decoder #(.DEBOUNCE_CYCLES(2), .STEP_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .encoder_value(ev1), .step_cw(cw1), .step_ccw(ccw1), .glitch(gl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position of a pair on the clockwise ring 00,01,11,10.
  function automatic int pos(logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // State after one clock edge; raw is the pair present at that edge.
  function automatic mdl_t mdl_step(mdl_t m, logic rst, logic [1:0] raw, int dcyc, int sdiv);
    mdl_t r;
    logic [1:0] syn;
    int d;
    if (rst) return '0;
    r = m;
    syn = m.raw2;
    r.raw2 = m.raw1;
    r.raw1 = raw;
    r.n = (m.n < 2) ? m.n + 1 : 2;
    if (syn[1] != m.deb[1]) begin
      r.run_a = m.run_a + 1;
      if (r.run_a == dcyc) begin r.deb[1] = syn[1]; r.run_a = 0; end
    end else r.run_a = 0;
    if (syn[0] != m.deb[0]) begin
      r.run_b = m.run_b + 1;
      if (r.run_b == dcyc) begin r.deb[0] = syn[0]; r.run_b = 0; end
    end else r.run_b = 0;
    r.armed = m.armed | (m.n >= 2 && syn == m.deb);
    r.prev = m.deb;
    r.cw = 1'b0; r.ccw = 1'b0; r.gl = 1'b0;
    if (m.armed) begin
      d = (pos(m.deb) - pos(m.prev) + 4) % 4;
      if (d == 2) r.gl = 1'b1;
      else begin
        if (d == 1) r.acc = m.acc + 1;
        else if (d == 3) r.acc = m.acc - 1;
        if (r.acc == sdiv) begin
          r.acc = 0; r.val = (m.val + 1) % 4; r.cw = 1'b1;
        end else if (r.acc == -sdiv) begin
          r.acc = 0; r.val = (m.val + 3) % 4; r.ccw = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hold(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(logic a, logic b, int n);
    enc_a = a;
    enc_b = b;
    hold(n);
  endtask

  task automatic clr();
    cnt_cw8 = 0; cnt_ccw8 = 0; cnt_gl8 = 0; cnt_cw1 = 0; cnt_ccw1 = 0; jump8 = 0;
    seq8.delete();
  endtask

  always @(posedge clk) begin
    m8 = mdl_step(m8, reset, {enc_a, enc_b}, 8, 4);
    m1 = mdl_step(m1, reset, {enc_a, enc_b}, 2, 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("value8",  int'($unsigned(ev8)), m8.val);
      chk("cw8",     int'(cw8),  int'(m8.cw));
      chk("ccw8",    int'(ccw8), int'(m8.ccw));
      chk("glitch8", int'(gl8),  int'(m8.gl));
      chk("value1",  int'($unsigned(ev1)), m1.val);
      chk("cw1",     int'(cw1),  int'(m1.cw));
      chk("ccw1",    int'(ccw1), int'(m1.ccw));
      chk("glitch1", int'(gl1),  int'(m1.gl));
    end
  end

  // Pulse counters and value-change history, sampled just after each edge.
  always @(posedge clk) begin
    #2;
    cnt_cw8  += int'(cw8);
    cnt_ccw8 += int'(ccw8);
    cnt_gl8  += int'(gl8);
    cnt_cw1  += int'(cw1);
    cnt_ccw1 += int'(ccw1);
    now8 = $unsigned(ev8);
    if (now8 != last8) begin
      if (!reset) begin
        if (2'(now8 - last8) == 2'd2) jump8++;
        seq8.push_back(int'(now8));
      end
      last8 = now8;
    end
  end

  initial begin
    logic [1:0] cur, nxt;
    int r;
    ring = '{2'b00, 2'b01, 2'b11, 2'b10};
    exp_seq = '{3, 2, 1, 0, 3};
    m8 = '0; m1 = '0;
    n_cmp = 0; n_bad = 0; chk_en = 1'b0; last8 = 2'b00;
    enc_a = 1'b0; enc_b = 1'b0; reset = 1'b1;
    clr();
    hold(3);
    chk_en = 1'b1;
    chk("rst_value", int'($unsigned(ev8)), 0);
    chk("rst_cw", int'(cw8), 0);
    chk("rst_ccw", int'(ccw8), 0);
    chk("rst_glitch", int'(gl8), 0);
    chk("rst_armed", int'(dut.armed_q), 0);
    reset = 1'b0;
    hold(5);

    // One full CW cycle, final edge latency measured edge by edge.
    clr();
    drive(0, 1, 20);
    drive(1, 1, 20);
    drive(1, 0, 20);
    enc_a = 1'b0; enc_b = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("lat_cw_early", int'(cw8), 0);
        chk("lat_value_early", int'($unsigned(ev8)), 0);
      end
      if (k == 11) begin
        chk("lat_cw_at11", int'(cw8), 1);
        chk("lat_value_at11", int'($unsigned(ev8)), 1);
      end
    end
    hold(9);
    chk("cw_cycle_steps", cnt_cw8, 1);
    chk("cw_cycle_glitch", cnt_gl8, 0);

    // Five CCW cycles from zero.
    reset = 1'b1; hold(2); reset = 1'b0; hold(5);
    clr();
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 12);
      drive(1, 1, 12);
      drive(0, 1, 12);
      drive(0, 0, 12);
    end
    hold(15);
    chk("ccw_pulses", cnt_ccw8, 5);
    chk("ccw_cw_pulses", cnt_cw8, 0);
    chk("ccw_jumps", jump8, 0);
    chk("ccw_seq_len", seq8.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seq8.size()) chk("ccw_seq", seq8[i], exp_seq[i]);

    // Short bounce on channel A must not reach the debounced level.
    clr();
    enc_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bounce_level", int'(dut.u_deb_a.level_o), 0);
    end
    enc_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bounce_level", int'(dut.u_deb_a.level_o), 0);
    end
    chk("bounce_value", int'($unsigned(ev8)), 3);
    chk("bounce_pulses", cnt_cw8 + cnt_ccw8 + cnt_gl8, 0);

    // Simultaneous toggle is illegal; counting resumes from the new pair.
    clr();
    drive(1, 1, 15);
    chk("glitch_count", cnt_gl8, 1);
    chk("glitch_value", int'($unsigned(ev8)), 3);
    chk("glitch_steps", cnt_cw8 + cnt_ccw8, 0);
    drive(1, 0, 15);
    drive(0, 0, 15);
    drive(0, 1, 15);
    chk("after_glitch_nostep", cnt_cw8, 0);
    drive(1, 1, 15);
    chk("after_glitch_step", cnt_cw8, 1);
    chk("after_glitch_value", int'($unsigned(ev8)), 0);
    chk("after_glitch_count", cnt_gl8, 1);

    // Reset mid-step with inputs left at 11.
    drive(1, 0, 15);
    drive(0, 0, 15);
    drive(0, 1, 15);
    enc_a = 1'b1; enc_b = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_value", int'($unsigned(ev8)), 0);
    chk("rst2_pulses", int'(cw8) + int'(ccw8) + int'(gl8), 0);
    chk("rst2_armed", int'(dut.armed_q), 0);
    clr();
    hold(20);
    chk("rearm_armed", int'(dut.armed_q), 1);
    chk("rearm_pulses", cnt_cw8 + cnt_ccw8 + cnt_gl8, 0);
    chk("rearm_value", int'($unsigned(ev8)), 0);
    drive(1, 0, 15);
    drive(0, 0, 15);
    drive(0, 1, 15);
    chk("acc_restart_nostep", cnt_cw8, 0);
    drive(1, 1, 15);
    chk("acc_restart_step", cnt_cw8, 1);
    chk("acc_restart_value", int'($unsigned(ev8)), 1);

    // STEP_DIV=1 instance: alternating single transitions.
    enc_a = 1'b0; enc_b = 1'b0; reset = 1'b1;
    hold(2);
    reset = 1'b0;
    hold(8);
    clr();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(0, 1, 8);
      else            drive(0, 0, 8);
      chk("div1_value", int'($unsigned(ev1)), (i % 2 == 0) ? 1 : 0);
      chk("div1_cw", cnt_cw1, i / 2 + 1);
      chk("div1_ccw", cnt_ccw1, (i + 1) / 2);
    end

    // Random walk with bounces, illegal toggles and occasional resets.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      cur = {enc_a, enc_b};
      nxt = cur;
      if (r < 40)      nxt = ring[(pos(cur) + 1) % 4];
      else if (r < 80) nxt = ring[(pos(cur) + 3) % 4];
      else if (r < 90) nxt = cur ^ 2'b11;
      else if (r < 97) nxt = cur ^ 2'b10;
      else begin
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
      end
      enc_a = nxt[1];
      enc_b = nxt[0];
      hold($urandom_range(1, 14));
    end
    hold(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
